// File: rtl/ad9708_play_ctrl_if.sv
// -----------------------------------------------------------------------------
// ad9708_play_ctrl_if
//
// AXI-Stream sample channel between the SG-DMA MM2S port and the AD9708
// playback sequencer.
//
//   tdata   packed samples, sample0 in the low byte
//   tvalid  word available from the DMA
//   tlast   last word of the DMA packet
//   tready  sequencer can take the word this cycle
//
// Modports: master = DMA side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface ad9708_play_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad9708_play_ctrl.sv
// -----------------------------------------------------------------------------
// ad9708_play_ctrl
//
// Playback sequencer for the AD9708 8-bit DAC. Takes 32-bit packed words from
// the DMA stream, unpacks them into four samples (low byte first) and paces
// them to the DAC at one sample every cfg_rate_div+1 clocks. Frame start, stop
// and length come from the register file; busy, a frame-done pulse and a
// saturating underrun count go back to it.
//
// Ports:
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   cfg_start          pulse: start a frame (ignored while busy)
//   cfg_stop           pulse: abort the frame, wins over cfg_start
//   cfg_rate_div       sample period minus one, latched at start
//   cfg_frame_len      frame length in words, latched at start
//   s_axis             sample stream (slave side)
//   dac_data/valid     registered sample and one-cycle strobe per sample
//   busy               frame in progress (WAIT_DATA, PLAY, DONE)
//   done_irq           one-cycle pulse when the frame has fully played
//   underrun_cnt       ticks that found no data, saturating
//
// Build option: define AD9708_IDLE_MIDSCALE_EN to park dac_data at midscale
// whenever the sequencer is idle; otherwise the last sample is held.
// -----------------------------------------------------------------------------
module ad9708_play_ctrl #(
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 8,
    parameter int DIV_W    = 16,
    parameter int LEN_W    = 24
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [DIV_W-1:0]    cfg_rate_div,
    input  logic [LEN_W-1:0]    cfg_frame_len,
    ad9708_play_ctrl_if.slave   s_axis,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                dac_valid,
    output logic                busy,
    output logic                done_irq,
    output logic [15:0]         underrun_cnt
);
    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_DATA, PLAY, DONE} state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_full;
    logic [1:0]          lane;        // next lane of hold_q to emit
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    rate_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    words_acc;
    logic                tlast_seen;

    logic                tick, room, lane_last, frame_end;
    logic                handshake, load, emit, underrun;
    logic [SAMPLE_W-1:0] lane_sample;

    assign tick        = (state == PLAY) && (div_cnt == rate_q);
    // More words may still be taken for this frame.
    assign room        = (words_acc < len_q) && !tlast_seen;
    assign lane_last   = (lane == 2'd3);
    // Final word fully emitted (or zero-length frame): nothing left to play.
    assign frame_end   = !hold_full && !room;
    assign handshake   = s_axis.tvalid && s_axis.tready;
    assign load        = handshake && !cfg_stop;
    assign emit        = tick && hold_full && !cfg_stop;
    assign underrun    = tick && !hold_full && room && !cfg_stop;
    assign lane_sample = hold_q[int'(lane)*SAMPLE_W +: SAMPLE_W];

    // ---------------------------------------------------------------- state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!ARESETN) state <= IDLE;
        else          state <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state;
        if (cfg_stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:      if (cfg_start) state_d = WAIT_DATA;
                // A zero-length frame drops straight through to DONE here,
                // one cycle after start, without ever raising tready.
                WAIT_DATA: if (frame_end)      state_d = DONE;
                           else if (handshake) state_d = PLAY;
                PLAY:      if (frame_end) state_d = DONE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy          = (state != IDLE);
        done_irq      = (state == DONE);
        s_axis.tready = 1'b0;
        case (state)
            WAIT_DATA: s_axis.tready = room;
            // Refill on the lane-3 tick keeps output gapless at rate_div=0.
            PLAY:      s_axis.tready = (!hold_full || (tick && lane_last)) && room;
            default:   s_axis.tready = 1'b0;
        endcase
    end

    // --------------------------------------------------------- holding data
    // NOTE: the holding word needs no reset; hold_full alone says whether
    // its contents mean anything.
    always_ff @(posedge ACLK) begin
        if (load) hold_q <= s_axis.tdata;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dac_data     <= MIDSCALE;
            dac_valid    <= 1'b0;
            underrun_cnt <= '0;
            hold_full    <= 1'b0;
            lane         <= '0;
            div_cnt      <= '0;
            rate_q       <= '0;
            len_q        <= '0;
            words_acc    <= '0;
            tlast_seen   <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
`ifdef AD9708_IDLE_MIDSCALE_EN
            if (state == IDLE) dac_data <= MIDSCALE;
`endif
            if (cfg_stop) begin
                hold_full <= 1'b0;
                lane      <= '0;
            end else begin
                case (state)
                    IDLE: if (cfg_start) begin
                        rate_q       <= cfg_rate_div;
                        len_q        <= cfg_frame_len;
                        words_acc    <= '0;
                        underrun_cnt <= '0;
                        tlast_seen   <= 1'b0;
                        hold_full    <= 1'b0;
                        lane         <= '0;
                    end
                    // The first handshake emits lane 0 straight away and
                    // restarts the divider, so lane 1 is the next to go.
                    WAIT_DATA: if (load) begin
                        dac_data  <= s_axis.tdata[SAMPLE_W-1:0];
                        dac_valid <= 1'b1;
                        lane      <= 2'd1;
                        div_cnt   <= '0;
                    end
                    PLAY: begin
                        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                        if (emit) begin
                            dac_data  <= lane_sample;
                            dac_valid <= 1'b1;
                            lane      <= lane + 2'd1;
                            if (lane_last) hold_full <= 1'b0;
                        end
                        if (underrun && (underrun_cnt != 16'hFFFF))
                            underrun_cnt <= underrun_cnt + 16'd1;
                        if (load) lane <= '0;
                    end
                    default: ;
                endcase
                if (load) begin
                    hold_full  <= 1'b1;
                    words_acc  <= words_acc + LEN_W'(1);
                    tlast_seen <= tlast_seen | s_axis.tlast;
                end
            end
        end
    end
endmodule

// File: tb/tb_ad9708_play_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ad9708_play_ctrl
//
// Directed bench for ad9708_play_ctrl. Stimulus pushes the samples it expects
// (with the required spacing in cycles) into a queue; a negedge monitor pops
// and compares every dac_valid strobe independently of the stimulus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad9708_play_ctrl;
    localparam int DATA_W = 32, SAMPLE_W = 8, DIV_W = 16, LEN_W = 24;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [DIV_W-1:0]    cfg_rate_div = '0;
    logic [LEN_W-1:0]    cfg_frame_len = '0;
    logic [SAMPLE_W-1:0] dac_data;
    logic                dac_valid, busy, done_irq;
    logic [15:0]         underrun_cnt;

    ad9708_play_ctrl_if #(.DATA_W(DATA_W)) s_axis ();

    ad9708_play_ctrl #(
        .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W), .LEN_W(LEN_W)
    ) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_rate_div(cfg_rate_div), .cfg_frame_len(cfg_frame_len),
        .s_axis(s_axis),
        .dac_data(dac_data), .dac_valid(dac_valid),
        .busy(busy), .done_irq(done_irq), .underrun_cnt(underrun_cnt)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [7:0] data;
        int         gap;   // cycles since previous sample; 0 = not checked
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   last_valid_cyc = 0;
    int   done_cnt = 0;

    task automatic expect_word(input logic [31:0] w, input int first_gap, input int gap);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.data = w[8*i +: 8];
            e.gap  = (i == 0) ? first_gap : gap;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (dac_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_sample: got 0x%0h, want no sample (cycle %0d)", dac_data, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sample_data", 32'(dac_data), 32'(mon_e.data));
                    if (mon_e.gap > 0) check("sample_gap", cyc - last_valid_cyc, mon_e.gap);
                end
                last_valid_cyc = cyc;
            end
            if (done_irq) done_cnt++;
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic start_frame(input logic [DIV_W-1:0] rd, input logic [LEN_W-1:0] len);
        cfg_rate_div  = rd;
        cfg_frame_len = len;
        cfg_start     = 1'b1;
        step(1);
        cfg_start     = 1'b0;
    endtask

    // Present one word and return one ns after the accepting edge.
    task automatic send_word(input logic [31:0] w, input logic last);
        bit ok = 1'b0;
        s_axis.tdata  = w;
        s_axis.tlast  = last;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk); #1;
            if (s_axis.tready) ok = 1'b1;
            @(posedge aclk); #1;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        check("handshake_in_time", 32'(ok), 1);
    endtask

    // Return one ns after the negedge of the done_irq cycle.
    task automatic wait_done(input int max, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge aclk); #1;
            if (done_irq) seen = 1'b1;
        end
        check(name, 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        int cnt, cnt2, d0, seen_at;
        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;

        // Reset state
        step(2);
        check("rst_dac_data", 32'(dac_data), 32'h80);
        check("rst_dac_valid", 32'(dac_valid), 0);
        check("rst_tready", 32'(s_axis.tready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_irq", 32'(done_irq), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        aresetn = 1'b1;
        step(2);

        // Basic frame: 8 gapless samples, done one cycle after the last.
        expect_word(32'h04030201, 0, 1);
        expect_word(32'h08070605, 1, 1);
        start_frame(16'd0, 24'd2);
        send_word(32'h04030201, 1'b0);
        send_word(32'h08070605, 1'b0);
        wait_done(40, "basic_done_seen");
        check("basic_done_lag", cyc - last_valid_cyc, 1);
        @(negedge aclk); #1;
        check("basic_busy_after_done", 32'(busy), 0);
        check("basic_irq_one_cycle", 32'(done_irq), 0);
        check("basic_sb_empty", sb_q.size(), 0);
        step(2);

        // Rate pacing: rate_div=3 spaces samples 4 cycles apart.
        expect_word(32'hDDCCBBAA, 0, 4);
        start_frame(16'd3, 24'd1);
        send_word(32'hDDCCBBAA, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk); #1;
            if (s_axis.tready) cnt++;
        end
        check("pace_tready_low", cnt, 0);
        wait_done(20, "pace_done_seen");
        check("pace_done_lag", cyc - last_valid_cyc, 1);
        check("pace_sb_empty", sb_q.size(), 0);
        step(2);

        // Underrun: second word accepted 17 cycles after the first; ticks at
        // +8,+10,+12,+14,+16 find the holding register empty.
        expect_word(32'h44332211, 0, 2);
        expect_word(32'h88776655, 12, 2);
        start_frame(16'd1, 24'd2);
        send_word(32'h44332211, 1'b0);
        step(16);
        check("ur_data_held", 32'(dac_data), 32'h44);
        check("ur_valid_low", 32'(dac_valid), 0);
        check("ur_count_gap", 32'(underrun_cnt), 5);
        send_word(32'h88776655, 1'b0);
        wait_done(40, "ur_done_seen");
        check("ur_count_final", 32'(underrun_cnt), 5);
        check("ur_sb_empty", sb_q.size(), 0);
        step(2);

        // Early tlast on word 2 of a 4-word frame; word 3 must be refused.
        expect_word(32'hA3A2A1A0, 0, 1);
        expect_word(32'hB3B2B1B0, 1, 1);
        start_frame(16'd0, 24'd4);
        send_word(32'hA3A2A1A0, 1'b0);
        send_word(32'hB3B2B1B0, 1'b1);
        s_axis.tdata  = 32'hC3C2C1C0;
        s_axis.tvalid = 1'b1;
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk); #1;
            if (s_axis.tready) cnt++;
            if (done_irq) cnt2++;
        end
        s_axis.tvalid = 1'b0;
        check("tlast_no_third_word", cnt, 0);
        check("tlast_done_once", cnt2, 1);
        check("tlast_tready_after", 32'(s_axis.tready), 0);
        check("tlast_sb_empty", sb_q.size(), 0);
        step(1);

        // Stop while lane 1 of word 0 is pending.
        sb_q.push_back('{data: 8'h31, gap: 0});
        d0 = done_cnt;
        start_frame(16'd3, 24'd2);
        send_word(32'h34333231, 1'b0);
        step(1);
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        @(negedge aclk); #1;
        check("stop_busy_low", 32'(busy), 0);
        check("stop_tready_low", 32'(s_axis.tready), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk); #1;
            if (dac_valid) cnt++;
        end
        check("stop_no_valid", cnt, 0);
        check("stop_no_irq", done_cnt - d0, 0);
`ifdef AD9708_IDLE_MIDSCALE_EN
        check("stop_dac_midscale", 32'(dac_data), 32'h80);
`else
        check("stop_dac_held", 32'(dac_data), 32'h31);
`endif
        check("stop_sb_empty", sb_q.size(), 0);
        step(1);

        // Zero length: done two cycles after start, tready never high.
        s_axis.tdata  = 32'hEEEEEEEE;
        s_axis.tvalid = 1'b1;
        d0 = done_cnt;
        start_frame(16'd0, 24'd0);
        cnt = 0;
        seen_at = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge aclk); #1;
            if (s_axis.tready) cnt++;
            if (done_irq && seen_at < 0) seen_at = i;
        end
        s_axis.tvalid = 1'b0;
        check("zero_done_lag", seen_at, 2);
        check("zero_tready_never", cnt, 0);
        check("zero_done_once", done_cnt - d0, 1);
        step(1);

        // Start and stop together: stop wins.
        cfg_frame_len = 24'd2;
        cfg_start     = 1'b1;
        cfg_stop      = 1'b1;
        step(1);
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        @(negedge aclk); #1;
        check("startstop_busy", 32'(busy), 0);
        step(3);
        check("startstop_still_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of PLAY.
        sb_q.push_back('{data: 8'h5D, gap: 0});
        start_frame(16'd0, 24'd2);
        send_word(32'h5A5B5C5D, 1'b0);
        @(negedge aclk); #2;
        aresetn = 1'b0;
        #1;
        check("arst_dac_data", 32'(dac_data), 32'h80);
        check("arst_dac_valid", 32'(dac_valid), 0);
        check("arst_tready", 32'(s_axis.tready), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done_irq", 32'(done_irq), 0);
        check("arst_underrun", 32'(underrun_cnt), 0);
        step(2);
        aresetn = 1'b1;
        step(5);
        check("final_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
